// File: rtl/lowp_pkg.sv
// lowp_pkg: types and helpers shared by the low-pass signal chain.
//
// Contents:
//   SAMPLE_W   width of the signed filter sample (28 bits)
//   sample_t   signed sample type used by the filter and the decimator
//   acc_width  width of a boxcar accumulator summing 2^dec_log2 samples
package lowp_pkg;

  localparam int SAMPLE_W = 28;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Summing 2^dec_log2 samples grows the magnitude by at most dec_log2 bits,
  // so this width can never overflow.
  function automatic int acc_width(input int dec_log2);
    return SAMPLE_W + dec_log2;
  endfunction

endpackage

// File: rtl/lowp_dec_acc.sv
// lowp_dec_acc: boxcar accumulator and window phase counter for the
// decimator. Reports the full window sum together with a one-cycle
// completion strobe on the sample that closes each window.
//
// Ports:
//   clock_in   system clock, rising edge
//   reset      asynchronous active-high reset
//   enable     sample strobe
//   clear      synchronous window restart (wins over enable)
//   signal_in  signed input sample
//   sum_o      accumulator plus current sample (valid when done_o=1)
//   done_o     high on the strobe that completes a window
//   phase_o    number of samples already in the current window
module lowp_dec_acc
  import lowp_pkg::*;
#(
  parameter int DEC_LOG2 = 4,
  localparam int ACC_W = acc_width(DEC_LOG2)
) (
  input  logic                    clock_in,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    clear,
  input  sample_t                 signal_in,
  output logic signed [ACC_W-1:0] sum_o,
  output logic                    done_o,
  output logic [DEC_LOG2-1:0]     phase_o
);

  // All ones in the phase counter marks the last sample of a window.
  localparam logic [DEC_LOG2-1:0] LAST_PHASE = '1;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [DEC_LOG2-1:0]     phase_q, phase_d;
  logic signed [ACC_W-1:0] sig_ext;

  assign sig_ext = {{DEC_LOG2{signal_in[SAMPLE_W-1]}}, signal_in};
  assign sum_o   = acc_q + sig_ext;
  assign done_o  = enable & ~clear & (phase_q == LAST_PHASE);
  assign phase_o = phase_q;

  // Accumulate on each strobe; the closing sample empties the accumulator
  // since its contribution is already carried out through sum_o.
  always_comb begin
    acc_d   = acc_q;
    phase_d = phase_q;
    if (clear) begin
      acc_d   = '0;
      phase_d = '0;
    end else if (enable) begin
      if (phase_q == LAST_PHASE) begin
        acc_d   = '0;
        phase_d = '0;
      end else begin
        acc_d   = sum_o;
        phase_d = phase_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      acc_q   <= '0;
      phase_q <= '0;
    end else begin
      acc_q   <= acc_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/lowp_decimate.sv
// lowp_decimate: decimating boxcar averager placed after the IIR low-pass.
// Sums 2^DEC_LOG2 samples and presents their average in a valid/ready
// output register with a sticky overrun flag.
//
// Build option: define LOWP_DECIMATE_ROUND_EN for round-half-up averaging;
// without it the average is a plain arithmetic shift (floor).
//
// Ports:
//   clock_in   system clock, rising edge
//   reset      asynchronous active-high reset
//   enable     sample strobe shared with the upstream filter
//   clear      synchronous restart; also drops dec_valid and overrun
//   signal_in  signed filtered sample
//   dec_out    signed averaged sample, stable while dec_valid=1
//   dec_valid  dec_out holds an unconsumed result
//   dec_ready  consumer takes dec_out when dec_valid & dec_ready
//   overrun    sticky: a result was overwritten before being consumed
//   phase      samples already in the current window
//
// The sample width comes from lowp_pkg::SAMPLE_W so it always matches the
// sample_t used by the upstream filter.
module lowp_decimate
  import lowp_pkg::*;
#(
  parameter int DEC_LOG2 = 4
) (
  input  logic                clock_in,
  input  logic                reset,
  input  logic                enable,
  input  logic                clear,
  input  sample_t             signal_in,
  output sample_t             dec_out,
  output logic                dec_valid,
  input  logic                dec_ready,
  output logic                overrun,
  output logic [DEC_LOG2-1:0] phase
);

  localparam int ACC_W = acc_width(DEC_LOG2);

  logic signed [ACC_W-1:0] win_sum;
  logic signed [ACC_W-1:0] rounded;
  logic                    win_done;
  sample_t                 average;

  sample_t dec_q, dec_d;
  logic    valid_q, valid_d;
  logic    overrun_q, overrun_d;

  lowp_dec_acc #(
    .DEC_LOG2 (DEC_LOG2)
  ) u_acc (
    .clock_in  (clock_in),
    .reset     (reset),
    .enable    (enable),
    .clear     (clear),
    .signal_in (signal_in),
    .sum_o     (win_sum),
    .done_o    (win_done),
    .phase_o   (phase)
  );

`ifdef LOWP_DECIMATE_ROUND_EN
  // Adding half an LSB of the result before flooring rounds half up. The
  // full-scale positive sum plus this offset still fits in ACC_W bits.
  localparam logic signed [ACC_W-1:0] HALF_LSB = ACC_W'(2 ** (DEC_LOG2 - 1));
  assign rounded = win_sum + HALF_LSB;
`else
  assign rounded = win_sum;
`endif

  // The shifted value always lies within sample range, so truncation is exact.
  assign average = sample_t'(rounded >>> DEC_LOG2);

  // Output register and handshake: a new result always loads; it only flags
  // overrun when it replaces a result that nobody is taking this cycle.
  always_comb begin
    dec_d     = dec_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (clear) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end else if (win_done) begin
      dec_d   = average;
      valid_d = 1'b1;
      if (valid_q && !dec_ready) begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && dec_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      dec_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      dec_q     <= dec_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign dec_out   = dec_q;
  assign dec_valid = valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_lowp_decimate.sv
// tb_lowp_decimate: self-checking bench for lowp_decimate (DEC_LOG2=4).
// A window-level reference model (a queue of the samples in the current
// window and an integer average) predicts every output after each cycle.
module tb_lowp_decimate;
  import lowp_pkg::*;

  localparam int DL = 4;
  localparam int N  = 16;

  logic          clock_in = 1'b0;
  logic          reset;
  logic          enable;
  logic          clear;
  logic          dec_ready;
  sample_t       signal_in;
  sample_t       dec_out;
  logic          dec_valid;
  logic          overrun;
  logic [DL-1:0] phase;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  longint winQ[$];
  longint expDec;
  bit     expValid;
  bit     expOverrun;

  always #5 clock_in = ~clock_in;

  lowp_decimate #(
    .DEC_LOG2 (DL)
  ) dut (
    .clock_in  (clock_in),
    .reset     (reset),
    .enable    (enable),
    .clear     (clear),
    .signal_in (signal_in),
    .dec_out   (dec_out),
    .dec_valid (dec_valid),
    .dec_ready (dec_ready),
    .overrun   (overrun),
    .phase     (phase)
  );

  // Average of a window sum: floor division, optionally after adding half.
  function automatic longint avgOf(input longint s);
    longint t;
    longint q;
`ifdef LOWP_DECIMATE_ROUND_EN
    t = s + N / 2;
`else
    t = s;
`endif
    q = t / N;
    if ((t % N) < 0) q = q - 1;
    return q;
  endfunction

  task automatic modelReset();
    winQ.delete();
    expDec     = 0;
    expValid   = 0;
    expOverrun = 0;
  endtask

  task automatic modelStep(input bit en, input bit clr, input longint x, input bit rdy);
    longint s;
    bit     completes;
    completes = 0;
    s = 0;
    if (clr) begin
      winQ.delete();
      expValid   = 0;
      expOverrun = 0;
    end else begin
      if (en) begin
        winQ.push_back(x);
        if (winQ.size() == N) begin
          foreach (winQ[i]) s += winQ[i];
          winQ.delete();
          completes = 1;
        end
      end
      if (completes) begin
        if (expValid && !rdy) expOverrun = 1;
        expDec   = avgOf(s);
        expValid = 1;
      end else if (expValid && rdy) begin
        expValid = 0;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                             input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".valid"}, dec_valid, expValid);
    checkOutput({tag, ".overrun"}, overrun, expOverrun);
    checkOutput({tag, ".phase"}, phase, winQ.size());
    checkOutput({tag, ".out"}, dec_out, expDec);
  endtask

  // One clock cycle: drive, clock, advance the model, compare everything.
  task automatic applyStimulus(input bit en, input bit clr, input longint x,
                               input bit rdy, input string tag);
    enable    = en;
    clear     = clr;
    signal_in = sample_t'(x);
    dec_ready = rdy;
    @(posedge clock_in);
    #1;
    modelStep(en, clr, x, rdy);
    checkAll(tag);
  endtask

  task automatic runConst(input int n, input longint x, input bit rdy, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, x, rdy, tag);
  endtask

  task automatic idle(input bit rdy, input string tag);
    applyStimulus(1'b0, 1'b0, 0, rdy, tag);
  endtask

  initial begin
    longint expRound;
    sample_t rv;

    reset     = 1'b1;
    enable    = 1'b0;
    clear     = 1'b0;
    dec_ready = 1'b1;
    signal_in = '0;
    modelReset();
    #12;
    checkAll("reset");
    reset = 1'b0;

    // Constant window
    runConst(16, 100, 1'b1, "const100");
    checkOutput("const100.final", dec_out, 100);
    checkOutput("const100.pulse", dec_valid, 1);
    checkOutput("const100.phase0", phase, 0);
    idle(1'b1, "const100.drain");
    checkOutput("const100.drop", dec_valid, 0);

    // Rounding boundaries
`ifdef LOWP_DECIMATE_ROUND_EN
    expRound = 1;
`else
    expRound = 0;
`endif
    runConst(8, 1, 1'b1, "halfpos");
    runConst(8, 0, 1'b1, "halfpos");
    checkOutput("halfpos.final", dec_out, expRound);
`ifdef LOWP_DECIMATE_ROUND_EN
    expRound = 0;
`else
    expRound = -1;
`endif
    runConst(8, -1, 1'b1, "halfneg");
    runConst(8, 0, 1'b1, "halfneg");
    checkOutput("halfneg.final", dec_out, expRound);

    // Full scale, both polarities
    runConst(16, 134217727, 1'b1, "fsPos");
    checkOutput("fsPos.final", dec_out, 134217727);
    runConst(16, -134217728, 1'b1, "fsNeg");
    checkOutput("fsNeg.final", dec_out, -134217728);

    // Overrun: two windows unread
    applyStimulus(1'b0, 1'b1, 0, 1'b0, "ovr.clear");
    runConst(16, 5, 1'b0, "ovr.w5");
    runConst(16, 7, 1'b0, "ovr.w7");
    checkOutput("ovr.out7", dec_out, 7);
    checkOutput("ovr.flag", overrun, 1);
    idle(1'b1, "ovr.read");
    checkOutput("ovr.validDrop", dec_valid, 0);
    checkOutput("ovr.sticky", overrun, 1);
    idle(1'b0, "ovr.hold");
    applyStimulus(1'b0, 1'b1, 0, 1'b0, "ovr.clear2");
    checkOutput("ovr.cleared", overrun, 0);

    // Completion coinciding with a handshake
    runConst(16, 3, 1'b0, "hs.w3");
    runConst(15, 9, 1'b0, "hs.w9");
    applyStimulus(1'b1, 1'b0, 9, 1'b1, "hs.last");
    checkOutput("hs.out9", dec_out, 9);
    checkOutput("hs.valid", dec_valid, 1);
    checkOutput("hs.noOverrun", overrun, 0);
    idle(1'b1, "hs.drain");

    // Asynchronous reset mid-window
    runConst(10, 50, 1'b1, "rst.partial");
    #2 reset = 1'b1;
    #1;
    modelReset();
    checkAll("rst.async");
    #3 reset = 1'b0;
    runConst(16, 20, 1'b1, "rst.after");
    checkOutput("rst.out20", dec_out, 20);
    idle(1'b1, "rst.drain");

    // Clear colliding with an enable discards that sample too
    runConst(10, 50, 1'b1, "clr.partial");
    applyStimulus(1'b1, 1'b1, 999, 1'b1, "clr.withEn");
    checkOutput("clr.phase0", phase, 0);
    runConst(16, 20, 1'b1, "clr.after");
    checkOutput("clr.out20", dec_out, 20);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rv = sample_t'($urandom);
      if ($urandom_range(0, 19) == 0) rv = {1'b0, {(SAMPLE_W-1){1'b1}}};
      if ($urandom_range(0, 19) == 0) rv = {1'b1, {(SAMPLE_W-1){1'b0}}};
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0,
                    longint'(rv), $urandom_range(0, 1) == 1, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lowp_decimate.md
Name: lowp_decimate

Overview:
- Decimating boxcar averager directly downstream of the 2nd-order IIR low-pass filter.
- Consumes the filter's 28-bit signed output on every enable strobe, sums 2^DEC_LOG2 consecutive samples, and emits their average as one reduced-rate sample.
- The output is held in a valid/ready register so slow readout logic (bus or serial) can take results without losing alignment.

Parameters:
- SAMPLE_W, 28: signed sample width of input and output.
- DEC_LOG2, 4: log2 of the decimation ratio (16 samples per output). Legal range 1..8.

Ports:
- clock_in  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  sample strobe; the same strobe that advances the upstream filter.
- clear  input  1  synchronous restart of the accumulation window.
- signal_in  input  SAMPLE_W  signed filtered sample (filter signal_out).
- dec_out  output  SAMPLE_W  signed averaged sample; stable while dec_valid=1.
- dec_valid  output  1  dec_out holds an unconsumed result.
- dec_ready  input  1  consumer accepts dec_out when dec_valid & dec_ready.
- overrun  output  1  sticky flag: a result was overwritten before it was consumed.
- phase  output  DEC_LOG2  number of samples already in the current window.

Behaviour:
- Reset (async, reset=1) forces:
  - accumulator = 0, phase = 0
  - dec_out = 0, dec_valid = 0, overrun = 0
- Accumulator:
  - Signed, SAMPLE_W+DEC_LOG2 bits wide; it can never overflow.
  - Sign-extend signal_in before adding.
- Window accumulation (enable=1 and phase < 2^DEC_LOG2-1):
  - acc <= acc + signal_in; phase <= phase + 1.
- Window completion (enable=1 and phase = 2^DEC_LOG2-1):
  - Compute sum = acc + signal_in.
  - dec_out <= (sum + 2^(DEC_LOG2-1)) >>> DEC_LOG2, arithmetic shift (rounding per the optional feature).
  - dec_valid <= 1; acc <= 0; phase <= 0 (wraps).
- Latency: dec_out/dec_valid update on the clock edge that samples the last enable. They are visible the cycle after the final strobe.
- The result always fits SAMPLE_W bits: rounding of the full-scale positive case yields 2^(SAMPLE_W-1)-1, so no saturation logic is needed.
- enable=0: accumulator and phase hold.
- Handshake:
  - dec_valid & dec_ready with no completion that cycle: dec_valid <= 0.
  - Completion and handshake in the same cycle: the new result loads, dec_valid stays 1, overrun unchanged.
  - Completion while dec_valid=1 & dec_ready=0: the new result overwrites dec_out, dec_valid stays 1, overrun <= 1.
- overrun clears only on reset or clear.
- clear=1 (synchronous):
  - acc, phase, dec_valid and overrun go to 0; dec_out holds its last value.
  - clear has priority over enable in the same cycle; that sample is discarded.
- reset asserted mid-window discards the partial sum; the first window after release starts at phase 0.
- dec_out is a registered output; no combinational path from any input to any output.

Optional Feature:
- Macro LOWP_DECIMATE_ROUND_EN.
- Defined: round half up, i.e. add 2^(DEC_LOG2-1) before the arithmetic shift.
- Undefined: plain arithmetic shift (floor, toward minus infinity). This saves one adder and gives bit-exact truncation matching the software model's legacy mode.
- All other behaviour is identical.

Decomposition:
- Shared package lowp_pkg holds:
  - SAMPLE_W = 28
  - typedef sample_t (signed [SAMPLE_W-1:0])
  - function acc_width(dec_log2) returning SAMPLE_W+dec_log2
- The upstream filter and this block both import sample_t.
- One natural sub-module: lowp_dec_acc, containing the accumulator, phase counter and completion pulse. The top level adds the output register, handshake and overrun.

Test Plan (DEC_LOG2=4, dec_ready=1 unless noted):
- Constant 100 for 16 enables -> dec_valid pulses one cycle after the 16th strobe, dec_out=100, phase back to 0.
- 8 samples of 1 then 8 of 0 -> dec_out=1 with LOWP_DECIMATE_ROUND_EN, 0 without. 8 of -1 then 8 of 0 -> 0 with, -1 without.
- 16x +134217727 -> dec_out=134217727. 16x -134217728 -> dec_out=-134217728. No wrap either way.
- dec_ready=0, two full windows (values 5 then 7) -> dec_out=7, overrun=1. Raise dec_ready -> dec_valid drops next cycle, overrun stays 1 until clear.
- Completion in the same cycle as dec_ready handshake -> new value loads, dec_valid remains 1, overrun=0.
- 10 enables of 50, then async reset pulse between clock edges, then 16 enables of 20 -> outputs go to 0 immediately on reset; next dec_out=20 with no residue from the first 10 samples. Repeat using clear in the same cycle as an enable -> that sample is discarded.
